// File: rtl/key_expansion_128_iter.sv
// Iterative AES-128 key schedule: registers the cipher key, then streams round keys 0..10
// over a valid/ready handshake, producing one new round key per accepted key.
// Optional macro KEY_CACHE_EN adds an 11-entry round-key store with a registered read port
// for reverse-order (decryption) use.
module key_expansion_128_iter #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         sched_done
`ifdef KEY_CACHE_EN
    ,
    input  logic [3:0]   rk_rd_addr,
    output logic [127:0] rk_rd_data,
    output logic         cache_full
`endif
);

    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

    typedef enum logic {StIdle, StStream} state_e;

    // GF(2^8) multiply by x, reduction polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (exponent bits 1..7 set); maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        r    = 8'h01;
        base = a;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            r    = gf_mul(r, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        unique case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    state_e       state_q;
    logic [127:0] rk_out_q;
    logic [3:0]   rk_round_q;
    logic         rk_valid_q;
    logic         key_ready_q;
    logic         sched_done_q;

    logic [3:0]   round_nxt;
    logic [31:0]  rot_w3;
    logic [31:0]  g_word;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key_d;
    logic         key_acc;
    logic         rk_acc;

    assign key_acc = (state_q == StIdle) && key_valid;
    assign rk_acc  = (state_q == StStream) && rk_ready;

    // g_function (RotWord, SubWord, Rcon) on w3, then the XOR chain into the next round key
    always_comb begin
        round_nxt  = rk_round_q + 4'd1;
        rot_w3     = {rk_out_q[23:0], rk_out_q[31:24]};
        g_word     = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                      sbox(rot_w3[15:8]), sbox(rot_w3[7:0])} ^ {rcon(round_nxt), 24'h000000};
        n0         = rk_out_q[127:96] ^ g_word;
        n1         = rk_out_q[95:64] ^ n0;
        n2         = rk_out_q[63:32] ^ n1;
        n3         = rk_out_q[31:0] ^ n2;
        next_key_d = {n0, n1, n2, n3};
    end

    // Sequencer FSM with registered handshake outputs; reset beats any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rk_out_q     <= '0;
            rk_round_q   <= '0;
            rk_valid_q   <= 1'b0;
            key_ready_q  <= 1'b1;
            sched_done_q <= 1'b0;
        end else begin
            sched_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (key_valid) begin
                        rk_out_q    <= key_in;
                        rk_round_q  <= '0;
                        rk_valid_q  <= 1'b1;
                        key_ready_q <= 1'b0;
                        state_q     <= StStream;
                    end
                end
                StStream: begin
                    if (rk_ready) begin
                        if (rk_round_q < LastRound) begin
                            rk_out_q   <= next_key_d;
                            rk_round_q <= round_nxt;
                        end else begin
                            // Round-10 key stays visible on rk_out after the schedule ends
                            rk_valid_q   <= 1'b0;
                            key_ready_q  <= 1'b1;
                            sched_done_q <= 1'b1;
                            state_q      <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign key_ready  = key_ready_q;
    assign rk_out     = rk_out_q;
    assign rk_round   = rk_round_q;
    assign rk_valid   = rk_valid_q;
    assign sched_done = sched_done_q;

`ifdef KEY_CACHE_EN
    logic [127:0] rk_mem [11];
    logic [10:0]  written_q;
    logic [127:0] rk_rd_data_q;
    logic         cache_full_q;

    // Round-key store: no reset needed, the written mask gates every read
    always_ff @(posedge clk) begin
        if (!rst && rk_acc) rk_mem[rk_round_q] <= rk_out_q;
    end

    // Written mask, registered read port and full flag
    always_ff @(posedge clk) begin
        if (rst) begin
            written_q    <= '0;
            rk_rd_data_q <= '0;
            cache_full_q <= 1'b0;
        end else begin
            if (key_acc) begin
                written_q    <= '0;
                cache_full_q <= 1'b0;
            end else if (rk_acc) begin
                written_q[rk_round_q] <= 1'b1;
                if (rk_round_q >= LastRound) cache_full_q <= 1'b1;
            end
            if ((rk_rd_addr <= LastRound) && written_q[rk_rd_addr]) begin
                rk_rd_data_q <= rk_mem[rk_rd_addr];
            end else begin
                rk_rd_data_q <= '0;
            end
        end
    end

    assign rk_rd_data = rk_rd_data_q;
    assign cache_full = cache_full_q;
`endif

endmodule

// File: tb/tb_key_expansion_128_iter.sv
// Bench for key_expansion_128_iter: FIPS-197 and all-zero key vectors fed through a
// scoreboard, plus back-pressure, ignored-key, mid-schedule reset and reset-priority cases.
module tb_key_expansion_128_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         sched_done;
`ifdef KEY_CACHE_EN
    logic [3:0]   rk_rd_addr;
    logic [127:0] rk_rd_data;
    logic         cache_full;
`endif

    always #5 clk = ~clk;

    key_expansion_128_iter dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .rk_out     (rk_out),
        .rk_round   (rk_round),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .sched_done (sched_done)
`ifdef KEY_CACHE_EN
        ,
        .rk_rd_addr (rk_rd_addr),
        .rk_rd_data (rk_rd_data),
        .cache_full (cache_full)
`endif
    );

    typedef struct {
        logic [127:0] key;
        logic [3:0]   round;
        logic [127:0] rk;
    } vec_t;

    localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZeroKey = 128'h0;

    vec_t vecs[13];
    vec_t exp_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_done = 0;

    task automatic check128(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard: every accepted round key is popped and compared
    always @(negedge clk) begin : monitor
        vec_t e;
        if (!rst && rk_valid && rk_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_key: got round %0d key %h, none expected",
                         rk_round, rk_out);
            end else begin
                e = exp_q.pop_front();
                check128("rk_out", rk_out, e.rk);
                check_int("rk_round", int'(rk_round), int'(e.round));
            end
        end
        if (sched_done) n_done++;
    end

    task automatic start_key(input logic [127:0] k);
        int ok;
        ok = 0;
        @(posedge clk);
        #1;
        key_in    = k;
        key_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].key == k) exp_q.push_back(vecs[i]);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (key_ready) begin
                ok = 1;
                break;
            end
        end
        check_int("key_ready_wait", ok, 1);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        @(negedge clk);
        check_int("rk_valid_t1", int'(rk_valid), 1);
        check_int("key_ready_t1", int'(key_ready), 0);
        check_int("rk_round_t1", int'(rk_round), 0);
    endtask

    task automatic wait_round(input logic [3:0] r);
        int ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rk_valid && rk_round == r) begin
                ok = 1;
                break;
            end
        end
        check_int("wait_round", ok, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{FipsKey, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1]  = '{FipsKey, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2]  = '{FipsKey, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3]  = '{FipsKey, 4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        vecs[4]  = '{FipsKey, 4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        vecs[5]  = '{FipsKey, 4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        vecs[6]  = '{FipsKey, 4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        vecs[7]  = '{FipsKey, 4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        vecs[8]  = '{FipsKey, 4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        vecs[9]  = '{FipsKey, 4'd9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[10] = '{FipsKey, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[11] = '{ZeroKey, 4'd0,  128'h0};
        vecs[12] = '{ZeroKey, 4'd1,  128'h62636363626363636263636362636363};

        rst       = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        rk_ready  = 1'b0;
`ifdef KEY_CACHE_EN
        rk_rd_addr = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_int("reset_key_ready", int'(key_ready), 1);
        check_int("reset_rk_valid", int'(rk_valid), 0);
        check128("reset_rk_out", rk_out, '0);
        check_int("reset_rk_round", int'(rk_round), 0);
        check_int("reset_sched_done", int'(sched_done), 0);
`ifdef KEY_CACHE_EN
        check_int("reset_cache_full", int'(cache_full), 0);
`endif

        // FIPS run: hold at round 3, stray key at round 5, run to completion
        rk_ready = 1'b1;
        start_key(FipsKey);
        wait_round(4'd2);
        @(posedge clk);
        #1;
        rk_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_int("hold_round", int'(rk_round), 3);
            check128("hold_rk_out", rk_out, vecs[3].rk);
        end
        @(posedge clk);
        #1;
        rk_ready = 1'b1;
        wait_round(4'd4);
        @(posedge clk);
        #1;
        key_in    = ~FipsKey;
        key_valid = 1'b1;
        @(negedge clk);
        check_int("busy_key_ready", int'(key_ready), 0);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        wait_round(4'd10);
        @(negedge clk);
        check_int("done_pulse", int'(sched_done), 1);
        check_int("done_rk_valid", int'(rk_valid), 0);
        check_int("done_key_ready", int'(key_ready), 1);
        check128("done_rk_out", rk_out, vecs[10].rk);
        check_int("done_rk_round", int'(rk_round), 10);
        @(negedge clk);
        check_int("done_pulse_end", int'(sched_done), 0);
        check_int("done_pulse_count", n_done, 1);
        check_int("fips_queue_drained", exp_q.size(), 0);

`ifdef KEY_CACHE_EN
        // Reverse-order reads from the round-key store
        for (int a = 10; a >= 0; a--) begin
            @(posedge clk);
            #1;
            rk_rd_addr = 4'(a);
            @(posedge clk);
            @(negedge clk);
            check128("cache_read", rk_rd_data, vecs[a].rk);
        end
        @(posedge clk);
        #1;
        rk_rd_addr = 4'd11;
        @(posedge clk);
        @(negedge clk);
        check128("cache_read_oob", rk_rd_data, '0);
        check_int("cache_full", int'(cache_full), 1);
`endif

        // Mid-schedule reset while round 6 is on offer
        start_key(FipsKey);
        wait_round(4'd5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_int("rst_rk_valid", int'(rk_valid), 0);
        check_int("rst_key_ready", int'(key_ready), 1);
        check128("rst_rk_out", rk_out, '0);
        check_int("rst_rk_round", int'(rk_round), 0);
        check_int("rst_queue_left", exp_q.size(), 5);
        exp_q.delete();

        // Fresh all-zero key restarts at round 0
        start_key(ZeroKey);
        wait_round(4'd1);
        @(posedge clk);
        #1;
        rk_ready = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_int("zero_queue_drained", exp_q.size(), 0);

        // Reset and key_valid together in IDLE: reset wins
        @(posedge clk);
        #1;
        rst       = 1'b1;
        key_in    = FipsKey;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        key_valid = 1'b0;
        @(negedge clk);
        check_int("rst_prio_rk_valid", int'(rk_valid), 0);
        check_int("rst_prio_key_ready", int'(key_ready), 1);
        check128("rst_prio_rk_out", rk_out, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
